// File: rtl/mem_arbiter.sv
// Shares one single-ported memory bus between the fetch port and the data port.
// state | meaning: IDLE = bus free; BUSY_IF = fetch cycle on bus; BUSY_DM = data cycle on bus
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_ce_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_data_o,
   output logic              if_ready_o,
   input  logic              dm_ce_i,
   input  logic              dm_we_i,
   input  logic [3:0]        dm_sel_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_data_i,
   output logic [DATA_W-1:0] dm_data_o,
   output logic              dm_ready_o,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [3:0]        bus_sel_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [DATA_W-1:0] bus_wdata_o,
   input  logic [DATA_W-1:0] bus_rdata_i,
   input  logic              bus_ack_i,
   output logic              stallreq_o,
   output logic              bus_err_o
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              if_ready_q, dm_ready_q;
   logic [DATA_W-1:0] if_data_q, dm_data_q;
   logic              bus_req_q, bus_we_q, bus_err_q;
   logic [3:0]        bus_sel_q;
   logic [ADDR_W-1:0] bus_addr_q;
   logic [DATA_W-1:0] bus_wdata_q;
   logic              stall;
   logic              done;

   assign stall = (dm_ce_i & ~dm_ready_q) | (if_ce_i & ~if_ready_q);
   assign done  = bus_ack_i | (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         if_ready_q  <= 1'b0;
         dm_ready_q  <= 1'b0;
         if_data_q   <= '0;
         dm_data_q   <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_err_q   <= 1'b0;
         bus_sel_q   <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
      end else begin
         bus_err_q <= 1'b0;
         // Pipeline advanced: drop both done flags; a completion below overrides.
         if (!stall) begin
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (dm_ce_i && !dm_ready_q) begin
                  state_q     <= BUSY_DM;
                  cnt_q       <= '0;
                  bus_req_q   <= 1'b1;
                  bus_we_q    <= dm_we_i;
                  bus_sel_q   <= dm_sel_i;
                  bus_addr_q  <= dm_addr_i;
                  bus_wdata_q <= dm_data_i;
               end else if (if_ce_i && !if_ready_q) begin
                  state_q    <= BUSY_IF;
                  cnt_q      <= '0;
                  bus_req_q  <= 1'b1;
                  bus_we_q   <= 1'b0;
                  bus_sel_q  <= 4'b1111;
                  bus_addr_q <= if_addr_i;
               end
            end
            BUSY_IF, BUSY_DM: begin
               if (done) begin
                  state_q   <= IDLE;
                  bus_req_q <= 1'b0;
                  bus_we_q  <= 1'b0;
                  bus_err_q <= ~bus_ack_i;
                  if (state_q == BUSY_DM) begin
                     dm_ready_q <= 1'b1;
                     dm_data_q  <= (bus_ack_i && !bus_we_q) ? bus_rdata_i : '0;
                  end else begin
                     if_ready_q <= 1'b1;
                     if_data_q  <= bus_ack_i ? bus_rdata_i : '0;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Stall request is forced low while reset is asserted.
   assign stallreq_o  = rst & stall;
   assign if_data_o   = if_data_q;
   assign if_ready_o  = if_ready_q;
   assign dm_data_o   = dm_data_q;
   assign dm_ready_o  = dm_ready_q;
   assign bus_req_o   = bus_req_q;
   assign bus_we_o    = bus_we_q;
   assign bus_sel_o   = bus_sel_q;
   assign bus_addr_o  = bus_addr_q;
   assign bus_wdata_o = bus_wdata_q;
   assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected bus cycles and port results are queued
// as stimulus is driven and popped when the arbiter issues or completes.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_ce_i = 1'b0;
   logic [31:0] if_addr_i = '0;
   logic [31:0] if_data_o;
   logic        if_ready_o;
   logic        dm_ce_i = 1'b0;
   logic        dm_we_i = 1'b0;
   logic [3:0]  dm_sel_i = '0;
   logic [31:0] dm_addr_i = '0;
   logic [31:0] dm_data_i = '0;
   logic [31:0] dm_data_o;
   logic        dm_ready_o;
   logic        bus_req_o, bus_we_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_addr_o, bus_wdata_o;
   logic [31:0] bus_rdata_i = '0;
   logic        bus_ack_i = 1'b0;
   logic        stallreq_o, bus_err_o;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ready_o(if_ready_o),
      .dm_ce_i(dm_ce_i), .dm_we_i(dm_we_i), .dm_sel_i(dm_sel_i), .dm_addr_i(dm_addr_i),
      .dm_data_i(dm_data_i), .dm_data_o(dm_data_o), .dm_ready_o(dm_ready_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
      .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
      .bus_ack_i(bus_ack_i), .stallreq_o(stallreq_o), .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk_wd;
   } bus_exp_t;

   bus_exp_t    bus_q[$];
   logic [31:0] if_q[$];
   logic [31:0] dm_q[$];
   int          issue_cyc[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int lat   = 1;
   int scnt  = 0;
   int wr_cnt  = 0;
   int err_cnt = 0;
   int n;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Slave: acks in the lat-th cycle of a bus cycle; lat=0 never acks.
   initial forever begin
      @(negedge clk);
      if (bus_req_o === 1'b1) begin
         bus_ack_i = (lat != 0) && (scnt + 1 >= lat);
         scnt++;
      end else begin
         bus_ack_i = 1'b0;
         scnt = 0;
      end
   end

   // Monitor: pops expectations on bus-cycle start and on done-flag rise.
   initial begin : monitor
      logic     prev_req, prev_if, prev_dm;
      bus_exp_t e;
      prev_req = 1'b0; prev_if = 1'b0; prev_dm = 1'b0;
      forever begin
         @(negedge clk);
         if (bus_req_o && !prev_req) begin
            issue_cyc.push_back(cyc);
            if (bus_we_o) wr_cnt++;
            chk("bus_q_nonempty", bus_q.size() != 0, 1);
            if (bus_q.size() != 0) begin
               e = bus_q.pop_front();
               chk("bus_addr", bus_addr_o, e.addr);
               chk("bus_we", bus_we_o, e.we);
               chk("bus_sel", bus_sel_o, e.sel);
               if (e.chk_wd) chk("bus_wdata", bus_wdata_o, e.wdata);
            end
         end
         if (if_ready_o && !prev_if) begin
            chk("if_q_nonempty", if_q.size() != 0, 1);
            if (if_q.size() != 0) chk("if_data", if_data_o, if_q.pop_front());
         end
         if (dm_ready_o && !prev_dm) begin
            chk("dm_q_nonempty", dm_q.size() != 0, 1);
            if (dm_q.size() != 0) chk("dm_data", dm_data_o, dm_q.pop_front());
         end
         if (bus_err_o) err_cnt++;
         prev_req = bus_req_o;
         prev_if  = if_ready_o;
         prev_dm  = dm_ready_o;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      // Reset state, with a pending request masked by reset
      repeat (2) @(posedge clk);
      #1;
      dm_ce_i = 1'b1;
      #1;
      chk("rst_stall", stallreq_o, 0);
      chk("rst_req", bus_req_o, 0);
      chk("rst_if_ready", if_ready_o, 0);
      chk("rst_dm_ready", dm_ready_o, 0);
      chk("rst_err", bus_err_o, 0);
      chk("rst_if_data", if_data_o, 0);
      chk("rst_dm_data", dm_data_o, 0);
      dm_ce_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Fetch only, zero-wait slave
      lat = 1;
      bus_rdata_i = 32'h3C011234;
      if_addr_i = 32'h100;
      bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h100, wdata: 32'h0, chk_wd: 1'b0});
      if_q.push_back(32'h3C011234);
      if_ce_i = 1'b1;
      #1;
      chk("f_stall0", stallreq_o, 1);
      tick();
      chk("f_req", bus_req_o, 1);
      chk("f_addr", bus_addr_o, 32'h100);
      chk("f_stall1", stallreq_o, 1);
      tick();
      chk("f_ready", if_ready_o, 1);
      chk("f_data", if_data_o, 32'h3C011234);
      chk("f_stall2", stallreq_o, 0);
      chk("f_req_off", bus_req_o, 0);
      if_ce_i = 1'b0;
      tick();
      chk("f_ready_clr", if_ready_o, 0);
      tick();

      // Both ports at once, DM write first, 2-cycle slave
      lat = 2;
      wr_cnt = 0;
      bus_rdata_i = 32'h11112222;
      dm_we_i = 1'b1; dm_addr_i = 32'h2000; dm_data_i = 32'hDEADBEEF; dm_sel_i = 4'b0011;
      if_addr_i = 32'h104;
      bus_q.push_back('{we: 1'b1, sel: 4'b0011, addr: 32'h2000, wdata: 32'hDEADBEEF, chk_wd: 1'b1});
      bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h104, wdata: 32'h0, chk_wd: 1'b0});
      dm_q.push_back(32'h0);
      if_q.push_back(32'h11112222);
      dm_ce_i = 1'b1;
      if_ce_i = 1'b1;
      n = 0;
      tick();
      while (stallreq_o && n < 40) begin
         n++;
         tick();
      end
      chk("both_cycles", n, 5);
      chk("both_if_ready", if_ready_o, 1);
      chk("both_dm_ready", dm_ready_o, 1);
      dm_ce_i = 1'b0;
      if_ce_i = 1'b0;
      tick();
      tick();
      chk("both_one_write", wr_cnt, 1);

      // No ack: timeout abort
      lat = 0;
      bus_rdata_i = 32'hAAAA5555;
      dm_we_i = 1'b0; dm_addr_i = 32'h3000; dm_data_i = 32'h0; dm_sel_i = 4'hF;
      bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h3000, wdata: 32'h0, chk_wd: 1'b1});
      dm_q.push_back(32'h0);
      dm_ce_i = 1'b1;
      n = 0;
      tick();
      while (bus_req_o && n < 40) begin
         n++;
         tick();
      end
      chk("to_req_cycles", n, 16);
      chk("to_err", bus_err_o, 1);
      chk("to_ready", dm_ready_o, 1);
      chk("to_data", dm_data_o, 0);
      dm_ce_i = 1'b0;
      tick();
      chk("to_err_off", bus_err_o, 0);
      chk("to_req_off", bus_req_o, 0);
      chk("to_err_cnt", err_cnt, 1);
      tick();

      // Ack on the final timeout cycle wins
      lat = 16;
      bus_rdata_i = 32'h0BADF00D;
      dm_addr_i = 32'h3004;
      bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h3004, wdata: 32'h0, chk_wd: 1'b1});
      dm_q.push_back(32'h0BADF00D);
      dm_ce_i = 1'b1;
      n = 0;
      tick();
      while (bus_req_o && n < 40) begin
         n++;
         tick();
      end
      chk("late_req_cycles", n, 16);
      chk("late_err", bus_err_o, 0);
      chk("late_ready", dm_ready_o, 1);
      dm_ce_i = 1'b0;
      tick();
      chk("late_err_cnt", err_cnt, 1);
      tick();

      // Asynchronous reset in the middle of a data cycle
      lat = 0;
      dm_we_i = 1'b1; dm_addr_i = 32'h4000; dm_data_i = 32'h12345678; dm_sel_i = 4'b1100;
      bus_q.push_back('{we: 1'b1, sel: 4'b1100, addr: 32'h4000, wdata: 32'h12345678, chk_wd: 1'b1});
      dm_ce_i = 1'b1;
      tick();
      tick();
      chk("ar_pre_req", bus_req_o, 1);
      #3;
      rst = 1'b0;
      #1;
      chk("ar_req", bus_req_o, 0);
      chk("ar_stall", stallreq_o, 0);
      chk("ar_dm_ready", dm_ready_o, 0);
      chk("ar_err", bus_err_o, 0);
      dm_ce_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      lat = 1;
      bus_rdata_i = 32'hCAFE0001;
      dm_we_i = 1'b0; dm_addr_i = 32'h4004; dm_data_i = 32'h0; dm_sel_i = 4'hF;
      bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h4004, wdata: 32'h0, chk_wd: 1'b1});
      dm_q.push_back(32'hCAFE0001);
      dm_ce_i = 1'b1;
      n = 0;
      tick();
      while (!dm_ready_o && n < 10) begin
         n++;
         tick();
      end
      chk("ar_fresh_ready", dm_ready_o, 1);
      chk("ar_fresh_cycles", n, 1);
      dm_ce_i = 1'b0;
      tick();
      tick();

      // Back-to-back fetches, ce held, address advanced after each clearing edge
      lat = 1;
      issue_cyc.delete();
      for (int k = 0; k < 3; k++) begin
         if_addr_i = 32'h200 + 32'(4 * k);
         bus_rdata_i = 32'hA5000000 | if_addr_i;
         bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: if_addr_i, wdata: 32'h0, chk_wd: 1'b0});
         if_q.push_back(bus_rdata_i);
         if_ce_i = 1'b1;
         n = 0;
         tick();
         while (!if_ready_o && n < 10) begin
            n++;
            tick();
         end
         chk("b2b_ready", if_ready_o, 1);
         if (k == 2) if_ce_i = 1'b0;
         tick();
         chk("b2b_clr", if_ready_o, 0);
      end
      tick();
      chk("b2b_issues", issue_cyc.size(), 3);
      if (issue_cyc.size() == 3) begin
         chk("b2b_gap1", issue_cyc[1] - issue_cyc[0], 3);
         chk("b2b_gap2", issue_cyc[2] - issue_cyc[1], 3);
      end

      chk("end_bus_q", bus_q.size(), 0);
      chk("end_if_q", if_q.size(), 0);
      chk("end_dm_q", dm_q.size(), 0);
      chk("end_err_cnt", err_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
